exmem_retire: RTL and testbench

EXMEM_RETIRE -- requirements
Module: exmem_retire

---
 rtl/exmem_retire_pkg.sv | 19 +
 rtl/exmem_retire_hilo_reg.sv | 25 ++
 rtl/exmem_retire.sv | 88 ++++++++
 tb/tb_exmem_retire.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/exmem_retire_pkg.sv
// rtl/exmem_retire_pkg.sv - shared constants and stage entry type for the EX/MEM retire stage
package exmem_retire_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Stage occupancy encoding; the stored valid bit is the state.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] addr;
    logic              we;
  } entry_t;

endpackage

// File: rtl/exmem_retire_hilo_reg.sv
// rtl/exmem_retire_hilo_reg.sv - architectural HI/LO register pair with a shared write enable
module hilo_reg
  import exmem_retire_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // Both halves of a multiply result land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end

endmodule

// File: rtl/exmem_retire.sv
// rtl/exmem_retire.sv - single-entry execute-to-writeback stage with HI/LO, forwarding and retire count
module exmem_retire
  import exmem_retire_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] ALU_hi,
  input  logic              RegWrite_in,
  input  logic [REG_AW-1:0] WriteRegister_in,
  input  logic              HiLoWrite,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              FwdA,
  output logic              FwdB,
  output logic [DATA_W-1:0] retired
);

  entry_t            entry;
  logic [DATA_W-1:0] retired_q;
  logic              accept;
  logic [0:0]        next_occ;
  logic              leaving;

  assign accept  = ex_valid & ~Stall & ~Flush;
  // A flushed entry is squashed, so it never counts as retired.
  assign leaving = entry.valid & ~Stall & ~Flush;

  // Occupancy transition: Flush empties, Stall holds, otherwise fill or bubble.
  always_comb begin
    next_occ = ST_EMPTY;
    if (Flush)         next_occ = ST_EMPTY;
    else if (Stall)    next_occ = entry.valid;
    else if (ex_valid) next_occ = ST_FULL;
    else               next_occ = ST_EMPTY;
  end

  // Stage entry register; index 0 is never marked as a register-file write.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      entry <= '0;
    end else begin
      entry.valid <= next_occ[0];
      if (Flush) begin
        entry.we <= 1'b0;
      end else if (accept) begin
        entry.data <= ALU_out;
        entry.addr <= WriteRegister_in;
        entry.we   <= RegWrite_in & (WriteRegister_in != REG_ZERO);
      end
    end
  end

  // Retire counter wraps naturally at the top of its range.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      retired_q <= '0;
    end else if (leaving) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  hilo_reg u_hilo (
    .clk   (Clk),
    .rst_n (Rst),
    .we    (accept & HiLoWrite),
    .hi_d  (ALU_hi),
    .lo_d  (ALU_out),
    .hi    (Hi),
    .lo    (Lo)
  );

  assign wb_we   = entry.valid & entry.we;
  assign wb_addr = entry.addr;
  assign wb_data = entry.data;
  assign retired = retired_q;
  assign FwdA    = wb_we & (wb_addr == rs_id);
  assign FwdB    = wb_we & (wb_addr == rt_id);

endmodule

// File: tb/tb_exmem_retire.sv
// tb/tb_exmem_retire.sv - directed scoreboard bench for exmem_retire
module tb_exmem_retire;

  logic        Clk, Rst, ex_valid, RegWrite_in, HiLoWrite, Stall, Flush;
  logic [31:0] ALU_out, ALU_hi;
  logic [4:0]  WriteRegister_in, rs_id, rt_id;
  logic        wb_we, FwdA, FwdB;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, Hi, Lo, retired;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        m_valid;
  logic [31:0] m_retired, m_hi, m_lo;

  exmem_retire dut (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid), .ALU_out(ALU_out), .ALU_hi(ALU_hi),
    .RegWrite_in(RegWrite_in), .WriteRegister_in(WriteRegister_in), .HiLoWrite(HiLoWrite),
    .Stall(Stall), .Flush(Flush), .rs_id(rs_id), .rt_id(rt_id),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .Hi(Hi), .Lo(Lo),
    .FwdA(FwdA), .FwdB(FwdB), .retired(retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the reference model, then check after the edge.
  task automatic cycle(input logic v, input logic [31:0] lo, input logic [31:0] hi,
                       input logic rw, input logic [4:0] wr, input logic hlw,
                       input logic st, input logic fl);
    logic acc;
    exp_t e;
    ex_valid = v; ALU_out = lo; ALU_hi = hi; RegWrite_in = rw;
    WriteRegister_in = wr; HiLoWrite = hlw; Stall = st; Flush = fl;
    acc = v & ~st & ~fl;
    if (m_valid && !st && !fl) m_retired = m_retired + 32'd1;
    if (acc) sb.push_back('{we: rw && (wr != 5'd0), addr: wr, data: lo});
    if (acc && hlw) begin m_hi = hi; m_lo = lo; end
    if (fl) m_valid = 1'b0;
    else if (!st) m_valid = acc;
    @(posedge Clk); #1;
    if (acc) begin
      e = sb.pop_front();
      chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
      chk("wb_data", wb_data, e.data);
    end
    if (!m_valid) chk("wb_we_empty", {31'd0, wb_we}, 32'd0);
    chk("retired", retired, m_retired);
    chk("hi", Hi, m_hi);
    chk("lo", Lo, m_lo);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_retired = '0; m_hi = '0; m_lo = '0;
  endtask

  initial begin
    model_reset();
    Rst = 1'b0; ex_valid = 0; ALU_out = 0; ALU_hi = 0; RegWrite_in = 0;
    WriteRegister_in = 0; HiLoWrite = 0; Stall = 0; Flush = 0; rs_id = 0; rt_id = 0;
    #2;
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    // Basic write to r8, then a bubble retires it.
    cycle(1, 32'h1234, 0, 1, 5'd8, 0, 0, 0);
    chk("r8_we", {31'd0, wb_we}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r8_retired", retired, 32'd1);

    // Write to index 0 never enables the register file or forwards.
    rs_id = 5'd0;
    cycle(1, 32'h5555, 0, 1, 5'd0, 0, 0, 0);
    chk("r0_fwda", {31'd0, FwdA}, 32'd0);

    // HI/LO write, then a stall with new inputs holds everything.
    cycle(1, 32'hBEEF, 32'hDEAD, 1, 5'd3, 1, 0, 0);
    chk("hilo_hi", Hi, 32'h0000DEAD);
    chk("hilo_lo", Lo, 32'h0000BEEF);
    cycle(1, 32'h7777, 32'h8888, 1, 5'd9, 1, 1, 0);
    chk("stall_data", wb_data, 32'h0000BEEF);
    chk("stall_addr", {27'd0, wb_addr}, 32'd3);
    chk("stall_we", {31'd0, wb_we}, 32'd1);

    // Flush beats Stall and ex_valid; a flushed entry is not counted.
    cycle(1, 32'h9999, 32'hAAAA, 1, 5'd4, 1, 1, 1);
    chk("flush_we", {31'd0, wb_we}, 32'd0);

    // Forwarding compare against the stored destination.
    rs_id = 5'd5; rt_id = 5'd6;
    cycle(1, 32'h0505, 0, 1, 5'd5, 0, 0, 0);
    chk("fwd_a", {31'd0, FwdA}, 32'd1);
    chk("fwd_b", {31'd0, FwdB}, 32'd0);
    rt_id = 5'd5; #1;
    chk("fwd_b_hit", {31'd0, FwdB}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);

    // Counter wrap from a forced near-top value.
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFFFFFF;
    chk("wrap_preload", retired, 32'hFFFFFFFF);
    cycle(1, 32'h11, 0, 1, 5'd1, 0, 0, 0);
    cycle(1, 32'h22, 0, 1, 5'd2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_value", retired, 32'h00000001);

    // Asynchronous reset while stalled with a full entry.
    cycle(1, 32'h3333, 32'h4444, 1, 5'd7, 1, 0, 0);
    Stall = 1'b1;
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    chk("arst_we", {31'd0, wb_we}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_hi", Hi, 32'd0);
    chk("arst_retired", retired, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    cycle(1, 32'h6666, 0, 1, 5'd10, 0, 0, 0);
    chk("post_rst_retired", retired, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
